// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution engine's X-vector input path.
// Vector length, sample width, index helpers and the per-bank fill state.
package conv_pkg;

  localparam int unsigned N     = 20;
  localparam int unsigned W     = 20;
  localparam int unsigned IDX_W = $clog2(N);

  typedef logic signed [W-1:0] sample_t;
  typedef logic                bank_sel_t;
  typedef logic [IDX_W-1:0]    idx_t;

  typedef enum logic {
    BankEmpty = 1'b0,
    BankFull  = 1'b1
  } bank_state_t;

  localparam idx_t IDX_LAST = idx_t'(N - 1);

  // Wrap is an explicit compare against N-1 because N need not be a power of two.
  function automatic idx_t idx_next(input idx_t i);
    return (i == IDX_LAST) ? '0 : idx_t'(i + idx_t'(1));
  endfunction

endpackage

// File: rtl/xvec_bank.sv
// One N-sample buffer bank: synchronous write port, asynchronous read port.
// Contents are cleared on reset so a discarded partial vector never leaks out.
module xvec_bank
  import conv_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_we,
  input  idx_t    i_waddr,
  input  sample_t i_wdata,
  input  idx_t    i_raddr,
  output sample_t o_rdata
);

  sample_t r_mem [N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/xvec_stream_tx.sv
// Ping-pong buffered transmitter: loads samples into one bank while streaming the
// other to the convolver's X port through a single registered valid/ready stage.
module xvec_stream_tx
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  sample_t     s_data_in,
  input  logic        s_valid,
  output logic        s_ready,
  output sample_t     m_data_out_x,
  output logic        m_valid_x,
  input  logic        m_ready_x,
  output logic        m_last_x,
  output logic [15:0] vec_sent
);

  bank_state_t r_bank_st [2];
  bank_state_t w_bank_st_nxt [2];
  bank_sel_t   r_wr_bank;
  bank_sel_t   r_rd_bank;
  idx_t        r_wr_idx;
  idx_t        r_rd_idx;
  sample_t     r_data;
  logic        r_valid;
  logic        r_last;
  logic [15:0] r_vec_sent;

  logic        w_wr_fire;
  logic        w_wr_done;
  logic        w_stage_en;
  logic        w_rd_fire;
  logic        w_rd_done;
  logic [1:0]  w_bank_we;
  sample_t     w_bank_rdata [2];

  // s_ready comes only from registered flags, never from s_valid.
  assign s_ready    = (r_bank_st[r_wr_bank] == BankEmpty);
  assign w_wr_fire  = s_valid && s_ready;
  assign w_wr_done  = w_wr_fire && (r_wr_idx == IDX_LAST);
  assign w_stage_en = !r_valid || m_ready_x;
  assign w_rd_fire  = w_stage_en && (r_bank_st[r_rd_bank] == BankFull);
  assign w_rd_done  = w_rd_fire && (r_rd_idx == IDX_LAST);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_bank_we[b] = w_wr_fire && (r_wr_bank == bank_sel_t'(b));

    xvec_bank u_bank (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_bank_we[b]),
      .i_waddr (r_wr_idx),
      .i_wdata (s_data_in),
      .i_raddr (r_rd_idx),
      .o_rdata (w_bank_rdata[b])
    );
  end

  // Set and clear always target different banks, so both may apply on one edge.
  always_comb begin
    w_bank_st_nxt = r_bank_st;
    if (w_wr_done) begin
      w_bank_st_nxt[r_wr_bank] = BankFull;
    end
    if (w_rd_done) begin
      w_bank_st_nxt[r_rd_bank] = BankEmpty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bank_st[0] <= BankEmpty;
      r_bank_st[1] <= BankEmpty;
    end else begin
      r_bank_st <= w_bank_st_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
    end else if (w_wr_fire) begin
      r_wr_idx <= idx_next(r_wr_idx);
      if (w_wr_done) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_bank <= 1'b0;
      r_rd_idx  <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else if (w_rd_fire) begin
      r_data   <= w_bank_rdata[r_rd_bank];
      r_last   <= (r_rd_idx == IDX_LAST);
      r_valid  <= 1'b1;
      r_rd_idx <= idx_next(r_rd_idx);
      if (w_rd_done) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end else if (w_stage_en) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vec_sent <= '0;
    end else if (r_valid && m_ready_x && r_last) begin
      r_vec_sent <= r_vec_sent + 16'd1;
    end
  end

  assign m_data_out_x = r_data;
  assign m_valid_x    = r_valid;
  assign m_last_x     = r_last;
  assign vec_sent     = r_vec_sent;

endmodule
